// File: rtl/twofish_pkg.sv
// twofish_pkg
// Shared constants and types for the Twofish MDS stage:
//   GF_POLY  - GF(2^8) field polynomial x^8+x^6+x^5+x^3+1
//   MDS      - 4x4 MDS coefficients, indexed [row][col]
//   mds_state_t - FSM state encoding for mds_serial
package twofish_pkg;

    localparam logic [8:0] GF_POLY = 9'h169;

    localparam logic [7:0] MDS [4][4] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mds_state_t;

endpackage

// File: rtl/FFmult.sv
// FFmult
// Combinational GF(2^8) multiplier over the Twofish field polynomial.
// Ports:
//   a  in  8  multiplicand
//   b  in  8  multiplier
//   y  out 8  product a*b mod GF_POLY
module FFmult
    import twofish_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    logic [7:0] prod;
    logic [7:0] shifted;

    // Shift-and-add: shifted walks through a*x^i, reduced each step.
    always_comb begin
        prod    = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

    assign y = prod;

endmodule

// File: rtl/mds_serial.sv
// mds_serial
// Iterative Twofish MDS stage: z = M*y over GF(2^8), one byte multiply
// per clock through a single shared FFmult.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid to capture a word
// CALC  | 16 multiply-accumulate cycles, cnt = {row, col}
// DONE  | out_valid high, result held until out_ready
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   in_word valid
//   in_ready   out  1   ready to accept (IDLE only)
//   in_word    in   32  y0 = [7:0] .. y3 = [31:24]
//   out_valid  out  1   out_word holds a finished result
//   out_ready  in   1   downstream accepts out_word
//   out_word   out  32  z0 = [7:0] .. z3 = [31:24]
module mds_serial
    import twofish_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);

    mds_state_t state, state_nxt;

    logic [31:0] y_q;
    logic [31:0] z_q;
    logic [3:0]  cnt;
    logic [7:0]  acc;

    logic [1:0]  row;
    logic [1:0]  col;
    logic [7:0]  coef;
    logic [7:0]  y_col;
    logic [7:0]  prod;

    assign row   = cnt[3:2];
    assign col   = cnt[1:0];
    assign coef  = MDS[row][col];
    assign y_col = y_q[{col, 3'b000} +: 8];

    FFmult u_ffmult (
        .a (coef),
        .b (y_col),
        .y (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == 4'd15) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 32'h0;
            z_q <= 32'h0;
            cnt <= 4'd0;
            acc <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        y_q <= in_word;
                        cnt <= 4'd0;
                        acc <= 8'h00;
                    end
                end
                ST_CALC: begin
                    acc <= (col == 2'd0) ? prod : (acc ^ prod);
                    if (col == 2'd3) begin
                        z_q[{row, 3'b000} +: 8] <= acc ^ prod;
                    end
                    if (cnt != 4'd15) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Partially written z is never visible; the word reads zero outside DONE.
    assign out_word = (state == ST_DONE) ? z_q : 32'h0;

endmodule

// File: tb/tb_mds_serial.sv
module tb_mds_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;

    int vectors = 0;
    int errors  = 0;
    int cycles;

    always #5 clk = ~clk;

    mds_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept edge, then count cycles until out_valid (bounded).
    task automatic start_and_wait(input logic [31:0] word);
        in_valid = 1'b1;
        in_word  = word;
        tick();
        in_valid = 1'b0;
        in_word  = 32'hDEAD_BEEF;
        check("busy_after_accept", {31'b0, in_ready}, 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check("latency", cycles, 32'd16);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", {31'b0, out_valid}, 32'd0);
        check("ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] word, input logic [31:0] exp);
        start_and_wait(word);
        check(tag, out_word, exp);
        handshake();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_word",  out_word,           32'h0);

        run("unit_y0",   32'h0000_0001, 32'hEFEF_5B01);
        run("unit_y1",   32'h0000_0100, 32'h015B_EFEF);
        run("reduction", 32'h0000_0002, 32'hB7B7_B602);
        run("linear",    32'h0000_0101, 32'hEEB4_B4EE);
        run("zero",      32'h0000_0000, 32'h0000_0000);
        run("unit_y3",   32'h0100_0000, 32'h5BEF_015B);

        // Stall in DONE for 10 cycles
        start_and_wait(32'h0000_0002);
        for (int i = 0; i < 10; i++) begin
            check("stall_word",  out_word,           32'hB7B7_B602);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_ready", {31'b0, in_ready},  32'd0);
            tick();
        end
        handshake();

        // New word offered during CALC must wait for the output handshake
        in_valid = 1'b1;
        in_word  = 32'h0000_0001;
        tick();
        in_word  = 32'h0000_0100;
        tick();
        tick();
        check("calc_not_ready", {31'b0, in_ready}, 32'd0);
        cycles = 2;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check("overlap_latency", cycles, 32'd16);
        check("overlap_result",  out_word, 32'hEFEF_5B01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("no_same_edge_accept", {31'b0, in_ready},  32'd1);
        check("overlap_idle_valid",  {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("second_accepted", {31'b0, in_ready}, 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check("second_latency", cycles, 32'd16);
        check("second_result",  out_word, 32'h015B_EFEF);
        handshake();

        // Reset mid-CALC at cnt=7
        in_valid = 1'b1;
        in_word  = 32'h0000_0101;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", {31'b0, in_ready},  32'd1);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_word",  out_word,           32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("midrst_no_result", {31'b0, out_valid}, 32'd0);
        run("after_reset", 32'h0000_0001, 32'hEFEF_5B01);

        // Reset beats in_valid
        rst      = 1'b1;
        in_valid = 1'b1;
        in_word  = 32'h0000_0002;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_wins_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check("rst_wins_valid", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mds_serial.md
# mds_serial

Iterative Twofish MDS stage that multiplies a 4-byte column vector by the fixed 4x4 MDS matrix over GF(2^8), using the field polynomial x^8+x^6+x^5+x^3+1 (0x169). It sits directly downstream of the key-dependent S-box outputs in the g-function and feeds the PHT. It reuses one instance of the existing combinational `FFmult` and does one byte multiply per clock. A valid/ready handshake is used on both sides.

## Interface
- No parameters. Widths are fixed by the Twofish algorithm.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block can accept a word (high only in IDLE).
- `in_word`  in  32  input vector; y0 = bits 7:0, y1 = 15:8, y2 = 23:16, y3 = 31:24.
- `out_valid`  out  1  `out_word` holds a finished result.
- `out_ready`  in  1  downstream accepts `out_word`.
- `out_word`  out  32  result; z0 = bits 7:0 through z3 = bits 31:24.

## Operation
- The function is z = M·y with each row zi = XOR over j of Mij·yj. Rows of M:
  - row 0: 01 EF 5B 5B
  - row 1: 5B EF EF 01
  - row 2: EF 5B 01 EF
  - row 3: EF 01 EF 5B
- FSM states: IDLE, CALC, DONE.
  - IDLE: `in_ready`=1. When `in_valid` is high, the block captures `in_word`, clears `cnt` and `acc`, and moves to CALC.
  - CALC: 4-bit `cnt`; row = cnt[3:2], col = cnt[1:0].
    - Each cycle `FFmult` gets a = Mrow,col and b = ycol.
    - `acc` <= `acc` XOR y, or just y when col==0.
    - When col==3, the block writes the byte `acc` XOR y into z[row].
    - When cnt==15, the block moves to DONE; otherwise `cnt` increments.
  - DONE: `out_valid`=1 and `out_word` holds z. When `out_ready` is high, the block moves to IDLE.
- The captured input register isolates the block: changes on `in_word` after acceptance have no effect.
- `out_word` is stable for the whole time `out_valid` is high.
- All arithmetic is GF(2^8): addition is XOR, multiplication is done by `FFmult`. No integer carries anywhere.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1, `out_valid`=0, `out_word`=0.
  - Internal registers: `cnt`=0, `acc`=0, captured y=0.
- Latency: the accepting edge is edge 0. Edges 1..16 perform the 16 multiplies. `out_valid` is high after edge 16, i.e. 16 cycles after acceptance.
- Throughput: at most one word per 18 cycles (accept, 16 compute, 1 DONE handshake). A new accept is possible on the edge after the output handshake, not on the same edge.
- `in_valid` while in CALC or DONE: `in_ready`=0, the word is not consumed, and the upstream must hold it.
- `out_ready` high before DONE: no effect. `out_ready` low in DONE: the block stalls indefinitely with outputs held.
- `rst` asserted in any state, including mid-CALC: the computation is aborted, everything returns to reset values on that edge, and no partial result is ever presented.
- `rst` and `in_valid` high together: reset wins and nothing is captured.

## Structure
- `twofish_pkg` holds:
  - the field polynomial constant 0x169;
  - the 16 MDS coefficients as a constant array indexed [row][col];
  - the FSM state encoding.
- `FFmult` is the one sub-module, instantiated exactly once with ports `a`, `b`, `y`. The rest of the logic is the FSM, the counter, the accumulator and the registers.

## Test plan
- Unit vector y0: reset, then `in_word`=0x00000001 -> after 16 cycles `out_valid`=1 and `out_word`=0xEFEF5B01.
- Unit vector y1: `in_word`=0x00000100 -> `out_word`=0x015BEFEF.
- Field reduction: `in_word`=0x00000002 -> 0xB7B7B602 (EF·02 reduces by 0x169 to B7).
- Linearity and zero:
  - 0x00000101 -> 0xEEB4B4EE.
  - 0x00000000 -> 0x00000000.
- Handshake:
  - Hold `out_ready`=0 for 10 cycles in DONE -> `out_word` stable and `in_ready`=0 throughout.
  - Assert `in_valid` with a different word during CALC -> the result is unchanged and the new word is accepted only after the output handshake.
- Reset mid-op: assert `rst` at CALC `cnt`=7 -> next cycle IDLE, `out_valid`=0, `out_word`=0. The next transaction of 0x00000001 still returns 0xEFEF5B01.
